vec_execute_pipe: RTL and testbench

- Parametrised, pipelined execute stage for the vector ASIP.
- Sits between register read and memory/writeback.
- Forwards operands from the two downstream stages and runs a per-lane ALU with a multi-cycle multiplier and a saturating byte-add for alpha composition.
- Drives a registered branch-condition output; the whole stage is valid/ready handshaked so it can stall.

---
 rtl/vec_execute_pipe_if.sv | 66 ++++++
 rtl/vec_execute_pipe.sv | 271 +++++++++++++++++++++++++++
 tb/tb_vec_execute_pipe.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vec_execute_pipe_if.sv
// ----------------------------------------------------------------------------
// vec_execute_pipe_if
//   Bundles the instruction-in handshake, operand/forwarding buses, the
//   branch-condition inputs and the result-out handshake of the vector
//   execute stage.
//
//   master : register-read side / downstream stages (drives instruction,
//            forwarding data and out_ready; observes results)
//   slave  : the execute stage itself
//
//   Signals
//     in_valid / in_ready     instruction handshake
//     op, vec_mode            operation and lane mode (1 = all lanes)
//     src_a, src_b            register-read operands (LANES*LW)
//     idx_a, idx_b            source register indices
//     fwdN_en/vec/dest/data   pending write from downstream stage N (1 nearer)
//     cond_en, jmp_type       conditional-jump qualifier and condition code
//     out_valid / out_ready   result handshake
//     result, jmp_sel         registered ALU result and jump decision
//     busy                    multiply in flight
// ----------------------------------------------------------------------------
interface vec_execute_pipe_if #(
    parameter int LANES = 4,
    parameter int LW    = 32,
    parameter int RIDX  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op;
    logic                  vec_mode;
    logic [LANES*LW-1:0]   src_a;
    logic [LANES*LW-1:0]   src_b;
    logic [RIDX-1:0]       idx_a;
    logic [RIDX-1:0]       idx_b;
    logic                  fwd1_en;
    logic                  fwd1_vec;
    logic [RIDX-1:0]       fwd1_dest;
    logic [LANES*LW-1:0]   fwd1_data;
    logic                  fwd2_en;
    logic                  fwd2_vec;
    logic [RIDX-1:0]       fwd2_dest;
    logic [LANES*LW-1:0]   fwd2_data;
    logic                  cond_en;
    logic [1:0]            jmp_type;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*LW-1:0]   result;
    logic                  jmp_sel;
    logic                  busy;

    modport master (
        output in_valid, op, vec_mode, src_a, src_b, idx_a, idx_b,
               fwd1_en, fwd1_vec, fwd1_dest, fwd1_data,
               fwd2_en, fwd2_vec, fwd2_dest, fwd2_data,
               cond_en, jmp_type, out_ready,
        input  in_ready, out_valid, result, jmp_sel, busy
    );

    modport slave (
        input  in_valid, op, vec_mode, src_a, src_b, idx_a, idx_b,
               fwd1_en, fwd1_vec, fwd1_dest, fwd1_data,
               fwd2_en, fwd2_vec, fwd2_dest, fwd2_data,
               cond_en, jmp_type, out_ready,
        output in_ready, out_valid, result, jmp_sel, busy
    );
endinterface

// File: rtl/vec_execute_pipe.sv
// ----------------------------------------------------------------------------
// vec_execute_pipe
//   Pipelined execute stage of the vector ASIP. Resolves operand forwarding
//   from the two downstream stages, runs a per-lane ALU (add/sub/logic/shift,
//   saturating byte add and a multi-cycle multiply), keeps Z/N/C/V flags from
//   lane 0 and produces a registered branch decision. The stage is fully
//   valid/ready handshaked and stalls under downstream back-pressure.
//
//   Ports
//     clk   clock
//     rst   asynchronous active-high reset
//     bus   vec_execute_pipe_if.slave (instruction in, result out)
//
//   Parameters
//     LANES    number of vector lanes (lane 0 is the scalar datapath)
//     LW       lane width, multiple of 8
//     MUL_LAT  cycles from multiply accept to out_valid (>= 2)
//     RIDX     register index width
// ----------------------------------------------------------------------------
module vec_execute_pipe #(
    parameter int LANES   = 4,
    parameter int LW      = 32,
    parameter int MUL_LAT = 3,
    parameter int RIDX    = 4
) (
    input  logic              clk,
    input  logic              rst,
    vec_execute_pipe_if.slave bus
);
    localparam int VW  = LANES * LW;
    localparam int SHW = $clog2(LW);
    localparam int CW  = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_SLL   = 3'b101,
        OP_MUL   = 3'b110,
        OP_SADD8 = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        JMP_ALWAYS = 2'b00,
        JMP_EQ     = 2'b01,
        JMP_NE     = 2'b10,
        JMP_LT     = 2'b11
    } jmp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    // ------------------------------------------------------------------
    // Per-lane ALU
    // ------------------------------------------------------------------
    function automatic logic [LW-1:0] lane_alu(op_e op, logic [LW-1:0] a, logic [LW-1:0] b);
        logic [LW-1:0] r;
        logic [8:0]    sum;
        r   = '0;
        sum = '0;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SLL: r = a << b[SHW-1:0];
            OP_MUL: r = a * b;   // low LW bits of the product
            OP_SADD8: begin
                // The 9th sum bit is the byte carry; it pins the byte at 8'hFF.
                for (int j = 0; j < LW / 8; j++) begin
                    sum = {1'b0, a[8*j +: 8]} + {1'b0, b[8*j +: 8]};
                    r[8*j +: 8] = sum[8] ? 8'hFF : sum[7:0];
                end
            end
        endcase
        return r;
    endfunction

    // Z/N from any result; C/V only meaningful for ADD/SUB.
    // C is carry-out on ADD and borrow on SUB.
    function automatic flags_t lane0_flags(op_e op, logic [LW-1:0] a, logic [LW-1:0] b,
                                           logic [LW-1:0] r);
        flags_t f;
        f   = '0;
        f.z = (r == '0);
        f.n = r[LW-1];
        case (op)
            OP_ADD: begin
                f.c = (r < a);
                f.v = (a[LW-1] == b[LW-1]) && (r[LW-1] != a[LW-1]);
            end
            OP_SUB: begin
                f.c = (a < b);
                f.v = (a[LW-1] != b[LW-1]) && (r[LW-1] != a[LW-1]);
            end
            default: ;
        endcase
        return f;
    endfunction

    function automatic logic jump_taken(jmp_e jt, flags_t f);
        logic t;
        case (jt)
            JMP_ALWAYS: t = 1'b1;
            JMP_EQ:     t = f.z;
            JMP_NE:     t = !f.z;
            JMP_LT:     t = f.n ^ f.v;
        endcase
        return t;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          out_valid_q;
    logic [VW-1:0] result_q;
    logic          jmp_sel_q;
    logic          busy_q;
    flags_t        flags_q;

    // Multiply operands and qualifiers captured at accept.
    logic [VW-1:0] mul_a_q;
    logic [VW-1:0] mul_b_q;
    logic          mul_vec_q;
    logic          mul_cond_q;
    jmp_e          mul_jt_q;

    logic          in_ready_d;
    logic          accept_d;
    op_e           op_d;
    logic [VW-1:0] opnd_a_d;
    logic [VW-1:0] opnd_b_d;
    logic [VW-1:0] alu_res_d;
    logic [VW-1:0] mul_res_d;
    flags_t        alu_flags_d;
    flags_t        mul_flags_d;

    // A new instruction may enter only from IDLE, and only if the current
    // output beat is empty or leaves this cycle (no bubble on hand-over).
    assign in_ready_d = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept_d   = bus.in_valid && in_ready_d;
    assign op_d       = op_e'(bus.op);

    // ------------------------------------------------------------------
    // Operand forwarding: nearer stage (fwd1) wins over fwd2.
    // A forward only hits when it targets the same register file.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        opnd_a_d = bus.src_a;
        opnd_b_d = bus.src_b;
        if (bus.fwd1_en && (bus.fwd1_vec == bus.vec_mode) && (bus.fwd1_dest == bus.idx_a))
            opnd_a_d = bus.fwd1_data;
        else if (bus.fwd2_en && (bus.fwd2_vec == bus.vec_mode) && (bus.fwd2_dest == bus.idx_a))
            opnd_a_d = bus.fwd2_data;
        if (bus.fwd1_en && (bus.fwd1_vec == bus.vec_mode) && (bus.fwd1_dest == bus.idx_b))
            opnd_b_d = bus.fwd1_data;
        else if (bus.fwd2_en && (bus.fwd2_vec == bus.vec_mode) && (bus.fwd2_dest == bus.idx_b))
            opnd_b_d = bus.fwd2_data;
    end

    // Scalar mode only computes lane 0; upper lanes read back as zero.
    always_comb begin
        alu_res_d = '0;
        mul_res_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i == 0 || bus.vec_mode)
                alu_res_d[i*LW +: LW] = lane_alu(op_d, opnd_a_d[i*LW +: LW], opnd_b_d[i*LW +: LW]);
            if (i == 0 || mul_vec_q)
                mul_res_d[i*LW +: LW] = lane_alu(OP_MUL, mul_a_q[i*LW +: LW], mul_b_q[i*LW +: LW]);
        end
    end

    assign alu_flags_d = lane0_flags(op_d, opnd_a_d[LW-1:0], opnd_b_d[LW-1:0], alu_res_d[LW-1:0]);
    assign mul_flags_d = lane0_flags(OP_MUL, mul_a_q[LW-1:0], mul_b_q[LW-1:0], mul_res_d[LW-1:0]);

    // NOTE: pure datapath capture registers carry no reset; they are only
    // consumed in ST_MUL, which is reachable solely through a fresh capture.
    always_ff @(posedge clk) begin
        if (accept_d && op_d == OP_MUL) begin
            mul_a_q    <= opnd_a_d;
            mul_b_q    <= opnd_b_d;
            mul_vec_q  <= bus.vec_mode;
            mul_cond_q <= bus.cond_en;
            mul_jt_q   <= jmp_e'(bus.jmp_type);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // A conditional jump is judged against flags_q as held before it, and
    // never writes the flags itself.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            jmp_sel_q   <= 1'b0;
            busy_q      <= 1'b0;
            flags_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (out_valid_q && bus.out_ready)
                        out_valid_q <= 1'b0;
                    if (accept_d) begin
                        if (op_d == OP_MUL) begin
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
                            cnt_q   <= CW'(MUL_LAT - 1);
                        end else begin
                            result_q    <= alu_res_d;
                            out_valid_q <= 1'b1;
                            jmp_sel_q   <= bus.cond_en && jump_taken(jmp_e'(bus.jmp_type), flags_q);
                            if (!bus.cond_en)
                                flags_q <= alu_flags_d;
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt_q == CNT_ONE) begin
                        result_q    <= mul_res_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        jmp_sel_q   <= mul_cond_q && jump_taken(mul_jt_q, flags_q);
                        if (!mul_cond_q)
                            flags_q <= mul_flags_d;
                        state_q     <= bus.out_ready ? ST_IDLE : ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.jmp_sel   = jmp_sel_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_vec_execute_pipe.sv
// ----------------------------------------------------------------------------
// tb_vec_execute_pipe
//   Directed bench for vec_execute_pipe (LANES=4, LW=32, MUL_LAT=3, RIDX=4).
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_vec_execute_pipe;
    localparam int LANES   = 4;
    localparam int LW      = 32;
    localparam int MUL_LAT = 3;
    localparam int RIDX    = 4;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010, OR = 3'b011,
                           XOR = 3'b100, SLL = 3'b101, MUL = 3'b110, SADD8 = 3'b111;
    localparam logic [1:0] J_AL = 2'b00, J_EQ = 2'b01, J_NE = 2'b10, J_LT = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    vec_execute_pipe_if #(.LANES(LANES), .LW(LW), .RIDX(RIDX)) bus ();

    vec_execute_pipe #(.LANES(LANES), .LW(LW), .MUL_LAT(MUL_LAT), .RIDX(RIDX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, confirm it can be taken, clock it in.
    task automatic issue(input logic [2:0] op, input logic vec,
                         input logic [127:0] a, input logic [127:0] b,
                         input logic cond, input logic [1:0] jt);
        bus.op       = op;
        bus.vec_mode = vec;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.cond_en  = cond;
        bus.jmp_type = jt;
        bus.in_valid = 1'b1;
        #1;
        check("in_ready_at_issue", 128'(bus.in_ready), 128'(1));
        step();
        bus.in_valid = 1'b0;
        bus.cond_en  = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = ADD;
        bus.vec_mode  = 1'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.idx_a     = 4'd1;
        bus.idx_b     = 4'd2;
        bus.fwd1_en   = 1'b0;
        bus.fwd1_vec  = 1'b0;
        bus.fwd1_dest = '0;
        bus.fwd1_data = '0;
        bus.fwd2_en   = 1'b0;
        bus.fwd2_vec  = 1'b0;
        bus.fwd2_dest = '0;
        bus.fwd2_data = '0;
        bus.cond_en   = 1'b0;
        bus.jmp_type  = J_AL;
        bus.out_ready = 1'b1;

        // ---- reset state ----
        repeat (3) step();
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_result",    bus.result,          128'(0));
        check("rst_jmp_sel",   128'(bus.jmp_sel),   128'(0));
        check("rst_busy",      128'(bus.busy),      128'(0));
        rst = 1'b0;
        step();
        check("idle_in_ready", 128'(bus.in_ready), 128'(1));

        // ---- vector ADD with lane wrap ----
        issue(ADD, 1'b1, {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 1'b0, J_AL);
        check("vadd_valid",  128'(bus.out_valid), 128'(1));
        check("vadd_result", bus.result, {32'd0, 32'd4, 32'd3, 32'd2});

        // ---- scalar SUB and conditional jumps, back-to-back ----
        issue(SUB, 1'b0, {{3{32'd7}}, 32'd5}, {{3{32'd9}}, 32'd5}, 1'b0, J_AL);
        check("ssub_zero_result", bus.result, 128'(0));
        check("ssub_jmp_sel",     128'(bus.jmp_sel), 128'(0));
        issue(ADD, 1'b0, 128'd1, 128'd1, 1'b1, J_EQ);
        check("jeq_taken",   128'(bus.jmp_sel), 128'(1));
        check("jeq_result",  bus.result, 128'd2);
        issue(ADD, 1'b0, 128'd1, 128'd1, 1'b1, J_NE);
        check("jne_flags_kept", 128'(bus.jmp_sel), 128'(0));
        issue(SUB, 1'b0, 128'd5, 128'd6, 1'b0, J_AL);
        check("ssub_neg_result", bus.result, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
        issue(ADD, 1'b0, 128'd0, 128'd0, 1'b1, J_EQ);
        check("jeq_not_taken", 128'(bus.jmp_sel), 128'(0));
        issue(ADD, 1'b0, 128'd0, 128'd0, 1'b1, J_LT);
        check("jlt_taken", 128'(bus.jmp_sel), 128'(1));
        issue(ADD, 1'b0, 128'h7FFF_FFFF, 128'd1, 1'b0, J_AL);
        check("sadd_ovf_result", bus.result, 128'h8000_0000);
        issue(ADD, 1'b0, 128'd0, 128'd0, 1'b1, J_LT);
        check("jlt_ovf_not_taken", 128'(bus.jmp_sel), 128'(0));
        issue(ADD, 1'b0, 128'd0, 128'd0, 1'b1, J_AL);
        check("jal_taken", 128'(bus.jmp_sel), 128'(1));

        // ---- forwarding priority ----
        bus.idx_a     = 4'd3;
        bus.idx_b     = 4'd5;
        bus.fwd1_en   = 1'b1;
        bus.fwd1_dest = 4'd3;
        bus.fwd1_data = 128'd10;
        bus.fwd2_en   = 1'b1;
        bus.fwd2_dest = 4'd3;
        bus.fwd2_data = 128'd20;
        issue(ADD, 1'b0, 128'd100, 128'd1, 1'b0, J_AL);
        check("fwd1_wins", bus.result, 128'd11);
        bus.fwd1_vec = 1'b1;
        issue(ADD, 1'b0, 128'd100, 128'd1, 1'b0, J_AL);
        check("fwd1_vec_miss", bus.result, 128'd21);
        bus.fwd2_vec = 1'b1;
        issue(ADD, 1'b0, 128'd100, 128'd1, 1'b0, J_AL);
        check("fwd_none", bus.result, 128'd101);
        bus.fwd1_en  = 1'b0;
        bus.fwd2_vec = 1'b0;
        bus.idx_a    = 4'd7;
        bus.idx_b    = 4'd3;
        issue(ADD, 1'b0, 128'd100, 128'd1, 1'b0, J_AL);
        check("fwd2_on_b", bus.result, 128'd120);
        bus.fwd2_en = 1'b0;
        bus.idx_a   = 4'd1;
        bus.idx_b   = 4'd2;

        // ---- logic, shift, saturating byte add ----
        issue(XOR, 1'b1, {32'hFFFF0000, 32'h12345678, 32'h0, 32'hAAAAAAAA},
                         {32'h0000FFFF, 32'h12345678, 32'h1, 32'h55555555}, 1'b0, J_AL);
        check("vxor", bus.result, {32'hFFFFFFFF, 32'h0, 32'h1, 32'hFFFFFFFF});
        issue(AND, 1'b0, 128'hFF00FF00, 128'h0FF00FF0, 1'b0, J_AL);
        check("sand", bus.result, 128'h0F000F00);
        issue(OR, 1'b0, 128'hFF00FF00, 128'h0FF00FF0, 1'b0, J_AL);
        check("sor", bus.result, 128'hFFF0FFF0);
        issue(SLL, 1'b0, 128'd1, 128'h25, 1'b0, J_AL);
        check("sll_mask", bus.result, 128'd32);
        issue(SADD8, 1'b1, {32'h0, 32'h0, 32'hFFFFFFFF, 32'h10F07F01},
                           {32'h0, 32'h0, 32'h01010101, 32'h20200102}, 1'b0, J_AL);
        check("vsadd8", bus.result, {32'h0, 32'h0, 32'hFFFFFFFF, 32'h30FF8003});

        // ---- scalar multiply latency ----
        issue(MUL, 1'b0, 128'h10000, 128'h10001, 1'b0, J_AL);
        check("mul_c1_busy",     128'(bus.busy),      128'(1));
        check("mul_c1_in_ready", 128'(bus.in_ready),  128'(0));
        check("mul_c1_valid",    128'(bus.out_valid), 128'(0));
        step();
        check("mul_c2_busy",     128'(bus.busy),      128'(1));
        check("mul_c2_in_ready", 128'(bus.in_ready),  128'(0));
        check("mul_c2_valid",    128'(bus.out_valid), 128'(0));
        step();
        check("mul_c3_valid",  128'(bus.out_valid), 128'(1));
        check("mul_c3_busy",   128'(bus.busy),      128'(0));
        check("mul_c3_result", bus.result,          128'h10000);

        // ---- vector multiply with jump, held under back-pressure ----
        issue(MUL, 1'b1, {32'd5, 32'd9, 32'hFFFFFFFF, 32'd7}, {32'd2, 32'd2, 32'd2, 32'h10}, 1'b1, J_NE);
        bus.out_ready = 1'b0;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            check("hold_valid",    128'(bus.out_valid), 128'(1));
            check("hold_result",   bus.result, {32'd10, 32'd18, 32'hFFFFFFFE, 32'h70});
            check("hold_jmp_sel",  128'(bus.jmp_sel),   128'(1));
            check("hold_in_ready", 128'(bus.in_ready),  128'(0));
            step();
        end
        bus.out_ready = 1'b1;
        step();
        check("hold_released", 128'(bus.out_valid), 128'(0));

        // ---- reset during multiply ----
        issue(MUL, 1'b0, 128'd3, 128'd4, 1'b0, J_AL);
        check("rmul_busy", 128'(bus.busy), 128'(1));
        rst = 1'b1;
        #1;
        check("rmul_valid_now", 128'(bus.out_valid), 128'(0));
        check("rmul_busy_now",  128'(bus.busy),      128'(0));
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rmul_no_output", 128'(bus.out_valid), 128'(0));
        end

        // ---- flags cleared by reset ----
        issue(ADD, 1'b0, 128'd2, 128'd3, 1'b1, J_NE);
        check("post_rst_jne", 128'(bus.jmp_sel), 128'(1));
        check("post_rst_add", bus.result,        128'd5);
        issue(ADD, 1'b0, 128'd2, 128'd3, 1'b1, J_EQ);
        check("post_rst_jeq", 128'(bus.jmp_sel), 128'(0));

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
